// File: rtl/stepdir_pulse_gen_if.sv
// Move-command channel between the register layer (master) and the step/dir
// pulse generator (slave).
interface stepdir_pulse_gen_if #(
  parameter int COUNT_W  = 16,
  parameter int PERIOD_W = 16
);
  // Handshake: a command transfers on the rising edge where cmd_valid and
  // cmd_ready are both high; the fields only need to be stable at that edge.
  // cmd_ready is high only while the generator is idle.
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_dir;
  logic [COUNT_W-1:0]  cmd_steps;
  logic [PERIOD_W-1:0] cmd_period;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_steps,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_steps,
    input  cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/stepdir_pulse_gen.sv
// Step/dir pulse source: runs one latched move command as a train of fixed-rate
// step pulses, with dir setup time, minimum high time and early abort.
module stepdir_pulse_gen #(
  parameter int COUNT_W  = 16,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                resetn,
  stepdir_pulse_gen_if.slave  cmd,
  input  logic [7:0]          config_pulse_width,
  input  logic [7:0]          config_dir_setup,
  input  logic                abort,
  output logic                step,
  output logic                dir,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  steps_remaining,
  output logic [2:0]          state_dbg
);

  localparam int CW = PERIOD_W + 1;
  localparam logic [CW-1:0]      CW_ONE    = CW'(1);
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DIR_SETUP  = 3'd1,
    PULSE_HIGH = 3'd2,
    PULSE_LOW  = 3'd3,
    FINISH     = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    pw_m1;
  logic [CW-1:0] low_m1;
  logic          abort_pend;
  logic          ready_q;

  // Effective timing for a command being accepted this cycle.
  logic [7:0]    pw_eff;
  logic [CW-1:0] pw_ext;
  logic [CW-1:0] pw_p1;
  logic [CW-1:0] per_ext;
  logic [CW-1:0] p_eff;
  logic [CW-1:0] low_m1_new;

  always_comb begin
    pw_eff     = (config_pulse_width == 8'd0) ? 8'd1 : config_pulse_width;
    pw_ext     = CW'(pw_eff);
    pw_p1      = pw_ext + CW_ONE;
    per_ext    = CW'(cmd.cmd_period);
    p_eff      = (per_ext >= pw_p1) ? per_ext : pw_p1;
    low_m1_new = p_eff - pw_ext - CW_ONE;
  end

  assign cmd.cmd_ready = ready_q;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      cnt             <= '0;
      pw_m1           <= '0;
      low_m1          <= '0;
      abort_pend      <= 1'b0;
      ready_q         <= 1'b1;
      step            <= 1'b0;
      dir             <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      steps_remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd.cmd_valid && ready_q) begin
            abort_pend <= 1'b0;
            pw_m1      <= pw_eff - 8'd1;
            low_m1     <= low_m1_new;
            ready_q    <= 1'b0;
            if (cmd.cmd_steps == '0) begin
              state           <= FINISH;
              done            <= 1'b1;
              steps_remaining <= '0;
            end else if ((cmd.cmd_dir != dir) && (config_dir_setup != 8'd0)) begin
              state           <= DIR_SETUP;
              busy            <= 1'b1;
              dir             <= cmd.cmd_dir;
              cnt             <= CW'(config_dir_setup) - CW_ONE;
              steps_remaining <= cmd.cmd_steps;
            end else begin
              state           <= PULSE_HIGH;
              busy            <= 1'b1;
              dir             <= cmd.cmd_dir;
              step            <= 1'b1;
              cnt             <= pw_ext - CW_ONE;
              steps_remaining <= cmd.cmd_steps - COUNT_ONE;
            end
          end
        end

        DIR_SETUP: begin
          if (abort) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cnt == '0) begin
            state           <= PULSE_HIGH;
            step            <= 1'b1;
            cnt             <= CW'(pw_m1);
            steps_remaining <= steps_remaining - COUNT_ONE;
          end else begin
            cnt <= cnt - CW_ONE;
          end
        end

        // An abort seen mid-pulse is remembered so the pulse keeps its full width.
        PULSE_HIGH: begin
          if (cnt == '0) begin
            step <= 1'b0;
            if (abort_pend || abort) begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= PULSE_LOW;
              cnt   <= low_m1;
            end
          end else begin
            cnt <= cnt - CW_ONE;
            if (abort) abort_pend <= 1'b1;
          end
        end

        PULSE_LOW: begin
          if (abort || ((cnt == '0) && (steps_remaining == '0))) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cnt == '0) begin
            state           <= PULSE_HIGH;
            step            <= 1'b1;
            cnt             <= CW'(pw_m1);
            steps_remaining <= steps_remaining - COUNT_ONE;
          end else begin
            cnt <= cnt - CW_ONE;
          end
        end

        FINISH: begin
          state   <= IDLE;
          done    <= 1'b0;
          ready_q <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          step    <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepdir_pulse_gen.sv
// Directed bench for stepdir_pulse_gen: cycle-by-cycle step/busy/done checks
// against hand-computed windows for each move scenario.
module tb_stepdir_pulse_gen;

  logic        clk;
  logic        resetn;
  logic [7:0]  config_pulse_width;
  logic [7:0]  config_dir_setup;
  logic        abort;
  logic        step;
  logic        dir;
  logic        busy;
  logic        done;
  logic [15:0] steps_remaining;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  stepdir_pulse_gen_if #(.COUNT_W(16), .PERIOD_W(16)) cmd_bus ();

  stepdir_pulse_gen #(.COUNT_W(16), .PERIOD_W(16)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .cmd                (cmd_bus),
    .config_pulse_width (config_pulse_width),
    .config_dir_setup   (config_dir_setup),
    .abort              (abort),
    .step               (step),
    .dir                (dir),
    .busy               (busy),
    .done               (done),
    .steps_remaining    (steps_remaining),
    .state_dbg          (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // Driver: present a command and wait (bounded) for acceptance. On return the
  // accept edge T has passed and the next negedge lies in cycle T+1.
  task automatic issue_cmd(input logic d, input logic [15:0] n, input logic [15:0] per);
    int waited;
    waited = 0;
    @(negedge clk);
    cmd_bus.cmd_dir    = d;
    cmd_bus.cmd_steps  = n;
    cmd_bus.cmd_period = per;
    cmd_bus.cmd_valid  = 1'b1;
    while (cmd_bus.cmd_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 50) begin
      errors++;
      $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_bus.cmd_ready, waited);
    end
    @(posedge clk);
    #1;
    cmd_bus.cmd_valid  = 1'b0;
    cmd_bus.cmd_dir    = 1'($urandom_range(0, 1));
    cmd_bus.cmd_steps  = 16'($urandom_range(0, 65535));
    cmd_bus.cmd_period = 16'($urandom_range(0, 65535));
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    checks += 6;
    if (step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b, required 0", step); end
    if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b, required 0", dir); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    if (cmd_bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", cmd_bus.cmd_ready); end
    if (steps_remaining !== 16'd0) begin errors++; $display("FAIL reset_remaining: got %0d, required 0", steps_remaining); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Three pulses, P=10, PW=2; config is changed right after accept and must be ignored.
  task automatic test_basic();
    logic exp_step, exp_busy, exp_done;
    config_pulse_width = 8'd2;
    config_dir_setup   = 8'd0;
    issue_cmd(1'b0, 16'd3, 16'd10);
    config_pulse_width = 8'd7;
    config_dir_setup   = 8'd9;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      exp_step = (c >= 1 && c <= 2) || (c >= 11 && c <= 12) || (c >= 21 && c <= 22);
      exp_busy = (c <= 30);
      exp_done = (c == 31);
      checks += 4;
      if (step !== exp_step) begin errors++; $display("FAIL basic_step c=%0d: got %b, required %b", c, step, exp_step); end
      if (busy !== exp_busy) begin errors++; $display("FAIL basic_busy c=%0d: got %b, required %b", c, busy, exp_busy); end
      if (done !== exp_done) begin errors++; $display("FAIL basic_done c=%0d: got %b, required %b", c, done, exp_done); end
      if (dir !== 1'b0) begin errors++; $display("FAIL basic_dir c=%0d: got %b, required 0", c, dir); end
      if (c == 32) begin
        checks++;
        if (cmd_bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after c=%0d: got %b, required 1", c, cmd_bus.cmd_ready); end
      end
    end
  endtask

  // Direction change with D=5: pulse delayed by the setup window.
  task automatic test_dir_setup();
    logic exp_step, exp_busy, exp_done;
    config_pulse_width = 8'd3;
    config_dir_setup   = 8'd5;
    issue_cmd(1'b1, 16'd1, 16'd8);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      exp_step = (c >= 6 && c <= 8);
      exp_busy = (c <= 13);
      exp_done = (c == 14);
      checks += 4;
      if (step !== exp_step) begin errors++; $display("FAIL dirsetup_step c=%0d: got %b, required %b", c, step, exp_step); end
      if (busy !== exp_busy) begin errors++; $display("FAIL dirsetup_busy c=%0d: got %b, required %b", c, busy, exp_busy); end
      if (done !== exp_done) begin errors++; $display("FAIL dirsetup_done c=%0d: got %b, required %b", c, done, exp_done); end
      if (dir !== 1'b1) begin errors++; $display("FAIL dirsetup_dir c=%0d: got %b, required 1", c, dir); end
    end
  endtask

  // Period shorter than the pulse width is stretched to PW+1 (P=5).
  task automatic test_min_period();
    logic exp_step, exp_busy, exp_done;
    config_pulse_width = 8'd4;
    config_dir_setup   = 8'd5;
    issue_cmd(1'b1, 16'd2, 16'd1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      exp_step = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
      exp_busy = (c <= 10);
      exp_done = (c == 11);
      checks += 3;
      if (step !== exp_step) begin errors++; $display("FAIL minper_step c=%0d: got %b, required %b", c, step, exp_step); end
      if (busy !== exp_busy) begin errors++; $display("FAIL minper_busy c=%0d: got %b, required %b", c, busy, exp_busy); end
      if (done !== exp_done) begin errors++; $display("FAIL minper_done c=%0d: got %b, required %b", c, done, exp_done); end
    end
  endtask

  // Zero steps with a different requested dir: no pulse, dir holds at 1.
  task automatic test_zero_steps();
    logic exp_done, exp_ready;
    config_dir_setup = 8'd3;
    issue_cmd(1'b0, 16'd0, 16'd50);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      exp_done  = (c == 1);
      exp_ready = (c >= 2);
      checks += 5;
      if (step !== 1'b0) begin errors++; $display("FAIL zero_step c=%0d: got %b, required 0", c, step); end
      if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy c=%0d: got %b, required 0", c, busy); end
      if (dir !== 1'b1) begin errors++; $display("FAIL zero_dir c=%0d: got %b, required 1", c, dir); end
      if (done !== exp_done) begin errors++; $display("FAIL zero_done c=%0d: got %b, required %b", c, done, exp_done); end
      if (cmd_bus.cmd_ready !== exp_ready) begin errors++; $display("FAIL zero_ready c=%0d: got %b, required %b", c, cmd_bus.cmd_ready, exp_ready); end
    end
  endtask

  // Abort mid-pulse completes that pulse; then abort while idle is ignored.
  task automatic test_abort();
    logic exp_step, exp_busy, exp_done;
    config_pulse_width = 8'd4;
    config_dir_setup   = 8'd0;
    issue_cmd(1'b1, 16'd5, 16'd10);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      exp_step = (c >= 1 && c <= 4) || (c >= 11 && c <= 14);
      exp_busy = (c <= 14);
      exp_done = (c == 15);
      checks += 3;
      if (step !== exp_step) begin errors++; $display("FAIL abort_step c=%0d: got %b, required %b", c, step, exp_step); end
      if (busy !== exp_busy) begin errors++; $display("FAIL abort_busy c=%0d: got %b, required %b", c, busy, exp_busy); end
      if (done !== exp_done) begin errors++; $display("FAIL abort_done c=%0d: got %b, required %b", c, done, exp_done); end
      if (c == 1) begin
        checks++;
        if (steps_remaining !== 16'd4) begin errors++; $display("FAIL abort_remaining_first c=%0d: got %0d, required 4", c, steps_remaining); end
      end
      if (c >= 15) begin
        checks++;
        if (steps_remaining !== 16'd3) begin errors++; $display("FAIL abort_remaining_hold c=%0d: got %0d, required 3", c, steps_remaining); end
      end
      if (c >= 18) begin
        checks++;
        if (cmd_bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_idle_ready c=%0d: got %b, required 1", c, cmd_bus.cmd_ready); end
      end
      abort = (c == 12) || (c == 17);
    end
    abort = 1'b0;
  endtask

  // Reset asserted during the second pulse: outputs clear without a done strobe.
  task automatic test_reset_mid_move();
    config_pulse_width = 8'd2;
    config_dir_setup   = 8'd0;
    issue_cmd(1'b1, 16'd3, 16'd10);
    for (int c = 1; c <= 12; c++) @(negedge clk);
    checks++;
    if (step !== 1'b1) begin errors++; $display("FAIL rstmid_pre_step: got %b, required 1", step); end
    resetn = 1'b0;
    #1;
    checks += 5;
    if (step !== 1'b0) begin errors++; $display("FAIL rstmid_step: got %b, required 0", step); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    if (dir !== 1'b0) begin errors++; $display("FAIL rstmid_dir: got %b, required 0", dir); end
    if (steps_remaining !== 16'd0) begin errors++; $display("FAIL rstmid_remaining: got %0d, required 0", steps_remaining); end
    if (cmd_bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b, required 1", cmd_bus.cmd_ready); end
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks += 3;
      if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done c=%0d: got %b, required 0", c, done); end
      if (step !== 1'b0) begin errors++; $display("FAIL rstmid_after_step c=%0d: got %b, required 0", c, step); end
      if (cmd_bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_after_ready c=%0d: got %b, required 1", c, cmd_bus.cmd_ready); end
    end
  endtask

  initial begin
    cmd_bus.cmd_valid  = 1'b0;
    cmd_bus.cmd_dir    = 1'b0;
    cmd_bus.cmd_steps  = '0;
    cmd_bus.cmd_period = '0;
    config_pulse_width = 8'd1;
    config_dir_setup   = 8'd0;
    abort              = 1'b0;
    resetn             = 1'b0;

    test_reset();
    test_basic();
    test_dir_setup();
    test_min_period();
    test_zero_steps();
    test_abort();
    test_reset_mid_move();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
